// File: rtl/tex_mem_responder_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tex_mem_responder_if
//  Description : Word-request bus between the texture memory requester
//                (master) and the texture memory responder (slave).
//                Carries NUM_REQS independent request/response channels
//                plus the responder's performance counters.
//  Revision    : 1.0 - initial release
// ============================================================================
interface tex_mem_responder_if #(
    parameter int NUM_REQS   = 4,
    parameter int ADDR_WIDTH = 10,
    parameter int TAG_WIDTH  = 8
);
    logic [NUM_REQS-1:0]            req_valid;
    logic [NUM_REQS-1:0]            req_rw;
    logic [NUM_REQS*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQS*4-1:0]          req_byteen;
    logic [NUM_REQS*32-1:0]         req_data;
    logic [NUM_REQS*TAG_WIDTH-1:0]  req_tag;
    logic [NUM_REQS-1:0]            req_ready;
    logic [NUM_REQS-1:0]            rsp_valid;
    logic [NUM_REQS*32-1:0]         rsp_data;
    logic [NUM_REQS*TAG_WIDTH-1:0]  rsp_tag;
    logic [NUM_REQS-1:0]            rsp_ready;
    logic [31:0]                    perf_reads;
    logic [31:0]                    perf_stalls;

    modport master (
        output req_valid, req_rw, req_addr, req_byteen, req_data, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_tag, perf_reads, perf_stalls
    );

    modport slave (
        input  req_valid, req_rw, req_addr, req_byteen, req_data, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_tag, perf_reads, perf_stalls
    );
endinterface

`default_nettype wire

// File: rtl/tex_mem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tex_mem_responder
//  Description : Memory-side responder for the texture cache bus. Serves
//                NUM_REQS independent word channels from a shared SRAM,
//                returns read data with its tag after LATENCY cycles through
//                a per-channel credit-gated response queue.
//                Optional macro TEX_MEM_PERF_EN enables the perf counters;
//                when undefined both counters are tied to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module tex_mem_responder #(
    parameter int NUM_REQS       = 4,
    parameter int ADDR_WIDTH     = 10,
    parameter int TAG_WIDTH      = 8,
    parameter int LATENCY        = 2,
    parameter int RSP_QUEUE_SIZE = 4
) (
    input  wire                clk,
    input  wire                reset_n,
    tex_mem_responder_if.slave bus
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int PTR_W = $clog2(RSP_QUEUE_SIZE);
    localparam int CNT_W = PTR_W + 1;

    logic                           active_q;
    logic [31:0]                    mem_q [DEPTH];
    logic [NUM_REQS-1:0]            req_ready_w;
    logic [NUM_REQS-1:0]            req_fire_w;
    logic [NUM_REQS-1:0]            rd_fire_w;
    logic [NUM_REQS-1:0]            wr_fire_w;
    logic [NUM_REQS-1:0]            rsp_valid_w;
    logic [NUM_REQS*32-1:0]         rsp_data_w;
    logic [NUM_REQS*TAG_WIDTH-1:0]  rsp_tag_w;

    assign req_fire_w = bus.req_valid & req_ready_w;
    assign rd_fire_w  = req_fire_w & ~bus.req_rw;
    assign wr_fire_w  = req_fire_w &  bus.req_rw;

    assign bus.req_ready = req_ready_w;
    assign bus.rsp_valid = rsp_valid_w;
    assign bus.rsp_data  = rsp_data_w;
    assign bus.rsp_tag   = rsp_tag_w;

    // Holds req_ready low during reset and through the release edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            active_q <= 1'b0;
        end else begin
            active_q <= 1'b1;
        end
    end

    // Byte-enabled writes; iterating high to low lets the lowest channel win
    // each byte when several channels hit the same word in one cycle.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            for (int i = NUM_REQS - 1; i >= 0; i--) begin
                if (wr_fire_w[i]) begin
                    for (int b = 0; b < 4; b++) begin
                        if (bus.req_byteen[i*4 + b]) begin
                            mem_q[bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH]][b*8 +: 8]
                                <= bus.req_data[i*32 + b*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_REQS; i++) begin : g_chan
        logic [ADDR_WIDTH-1:0] addr_w;
        logic [TAG_WIDTH-1:0]  tag_w;
        logic [LATENCY-1:0]    pv_q;
        logic [31:0]           pd_q [LATENCY];
        logic [TAG_WIDTH-1:0]  pt_q [LATENCY];
        logic [31:0]           fifo_data_q [RSP_QUEUE_SIZE];
        logic [TAG_WIDTH-1:0]  fifo_tag_q  [RSP_QUEUE_SIZE];
        logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
        logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
        logic [CNT_W-1:0]      count_q, count_d;
        logic [CNT_W-1:0]      credit_q, credit_d;
        logic                  push_w;
        logic                  pop_w;

        assign addr_w = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign tag_w  = bus.req_tag[i*TAG_WIDTH +: TAG_WIDTH];
        assign push_w = pv_q[LATENCY-1];
        assign pop_w  = (count_q != '0) & bus.rsp_ready[i];

        assign rsp_valid_w[i]                       = (count_q != '0);
        assign rsp_data_w[i*32 +: 32]               = fifo_data_q[rd_ptr_q];
        assign rsp_tag_w[i*TAG_WIDTH +: TAG_WIDTH]  = fifo_tag_q[rd_ptr_q];
        assign req_ready_w[i] = active_q & (credit_q != CNT_W'(RSP_QUEUE_SIZE));

        // Read valid pipeline; the first stage samples on the fire edge so
        // queue entry lands LATENCY edges after the fire.
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                pv_q <= '0;
            end else begin
                pv_q[0] <= rd_fire_w[i];
                for (int s = 1; s < LATENCY; s++) begin
                    pv_q[s] <= pv_q[s-1];
                end
            end
        end

        // Read data/tag pipeline; qualified by pv_q so it needs no reset.
        always_ff @(posedge clk) begin
            pd_q[0] <= mem_q[addr_w];
            pt_q[0] <= tag_w;
            for (int s = 1; s < LATENCY; s++) begin
                pd_q[s] <= pd_q[s-1];
                pt_q[s] <= pt_q[s-1];
            end
        end

        // Response queue storage; credits guarantee a free slot on push.
        always_ff @(posedge clk) begin
            if (push_w) begin
                fifo_data_q[wr_ptr_q] <= pd_q[LATENCY-1];
                fifo_tag_q[wr_ptr_q]  <= pt_q[LATENCY-1];
            end
        end

        // Next-state for pointers, occupancy and outstanding-read credits.
        always_comb begin
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            if (push_w) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop_w) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d  = count_q + CNT_W'(push_w) - CNT_W'(pop_w);
            credit_d = credit_q + CNT_W'(rd_fire_w[i]) - CNT_W'(pop_w);
        end

        // Queue and credit state registers.
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
                credit_q <= '0;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                count_q  <= count_d;
                credit_q <= credit_d;
            end
        end
    end

`ifdef TEX_MEM_PERF_EN
    logic [31:0] perf_reads_q;
    logic [31:0] perf_stalls_q;
    logic [31:0] rd_count_w;

    // Number of read fires this cycle.
    always_comb begin
        rd_count_w = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            rd_count_w = rd_count_w + 32'(rd_fire_w[i]);
        end
    end

    // Free-running counters that wrap at 2^32.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            perf_reads_q  <= '0;
            perf_stalls_q <= '0;
        end else begin
            perf_reads_q <= perf_reads_q + rd_count_w;
            if (|(bus.req_valid & ~req_ready_w)) begin
                perf_stalls_q <= perf_stalls_q + 32'd1;
            end
        end
    end

    assign bus.perf_reads  = perf_reads_q;
    assign bus.perf_stalls = perf_stalls_q;
`else
    assign bus.perf_reads  = '0;
    assign bus.perf_stalls = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tex_mem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_tex_mem_responder
//  Description : Self-checking bench for tex_mem_responder. A transaction-
//                level model (word array + per-channel response queues with
//                due times) is compared against the DUT on every cycle, and
//                directed scenarios pin literal values. Honours
//                TEX_MEM_PERF_EN for the expected perf counter values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tex_mem_responder;

    localparam int NR  = 4;
    localparam int AW  = 10;
    localparam int TW  = 8;
    localparam int LAT = 2;
    localparam int QS  = 4;

    logic clk;
    logic reset_n;

    tex_mem_responder_if #(.NUM_REQS(NR), .ADDR_WIDTH(AW), .TAG_WIDTH(TW)) bus ();

    tex_mem_responder #(
        .NUM_REQS(NR), .ADDR_WIDTH(AW), .TAG_WIDTH(TW),
        .LATENCY(LAT), .RSP_QUEUE_SIZE(QS)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  tag;
        int          due;
    } rsp_t;

    logic [31:0] mem_m [1024];
    rsp_t        q_m [NR][$];
    bit          live     = 0;
    bit          active_m = 0;
    int          cyc      = 0;
    logic [31:0] pr_m     = 0;
    logic [31:0] ps_m     = 0;

    always @(negedge clk) begin : p_model
        bit [NR-1:0] rdy_m;
        bit [NR-1:0] vld_m;
        int          rdc;
        bit          stall;
        logic [AW-1:0] a;
        rdy_m = '0;
        vld_m = '0;
        if (live) begin
            for (int ch = 0; ch < NR; ch++) begin
                rdy_m[ch] = active_m && (q_m[ch].size() != QS);
                vld_m[ch] = (q_m[ch].size() > 0) && (q_m[ch][0].due <= cyc);
            end
            chk("req_ready", 64'(bus.req_ready), 64'(rdy_m));
            chk("rsp_valid", 64'(bus.rsp_valid), 64'(vld_m));
            for (int ch = 0; ch < NR; ch++) begin
                if (vld_m[ch]) begin
                    chk("rsp_data", 64'(bus.rsp_data[ch*32 +: 32]), 64'(q_m[ch][0].data));
                    chk("rsp_tag",  64'(bus.rsp_tag[ch*TW +: TW]),  64'(q_m[ch][0].tag));
                end
            end
            chk("perf_reads",  64'(bus.perf_reads),  64'(pr_m));
            chk("perf_stalls", 64'(bus.perf_stalls), 64'(ps_m));
        end
        if (!reset_n) begin
            for (int ch = 0; ch < NR; ch++) q_m[ch].delete();
            active_m = 0;
            pr_m     = 0;
            ps_m     = 0;
            live     = 1;
        end else if (live) begin
            for (int ch = 0; ch < NR; ch++) begin
                if (vld_m[ch] && bus.rsp_ready[ch]) void'(q_m[ch].pop_front());
            end
            rdc   = 0;
            stall = 0;
            for (int ch = 0; ch < NR; ch++) begin
                if (bus.req_valid[ch] && !rdy_m[ch]) stall = 1;
                if (bus.req_valid[ch] && rdy_m[ch] && !bus.req_rw[ch]) begin
                    a = bus.req_addr[ch*AW +: AW];
                    q_m[ch].push_back('{data: mem_m[a], tag: bus.req_tag[ch*TW +: TW],
                                        due: cyc + 1 + LAT});
                    rdc++;
                end
            end
            for (int ch = NR - 1; ch >= 0; ch--) begin
                if (bus.req_valid[ch] && rdy_m[ch] && bus.req_rw[ch]) begin
                    a = bus.req_addr[ch*AW +: AW];
                    for (int b = 0; b < 4; b++) begin
                        if (bus.req_byteen[ch*4 + b])
                            mem_m[a][b*8 +: 8] = bus.req_data[ch*32 + b*8 +: 8];
                    end
                end
            end
`ifdef TEX_MEM_PERF_EN
            pr_m = pr_m + 32'(rdc);
            if (stall) ps_m = ps_m + 1;
`endif
            active_m = 1;
        end
        cyc++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req();
        bus.req_valid  = '0;
        bus.req_rw     = '0;
        bus.req_addr   = '0;
        bus.req_byteen = '0;
        bus.req_data   = '0;
        bus.req_tag    = '0;
    endtask

    task automatic set_req(input int ch, input bit rw, input logic [AW-1:0] addr,
                           input logic [3:0] be, input logic [31:0] data, input logic [TW-1:0] tag);
        bus.req_valid[ch]             = 1'b1;
        bus.req_rw[ch]                = rw;
        bus.req_addr[ch*AW +: AW]     = addr;
        bus.req_byteen[ch*4 +: 4]     = be;
        bus.req_data[ch*32 +: 32]     = data;
        bus.req_tag[ch*TW +: TW]      = tag;
    endtask

    task automatic write_one(input int ch, input logic [AW-1:0] addr,
                             input logic [31:0] data, input logic [3:0] be);
        set_req(ch, 1'b1, addr, be, data, '0);
        step();
        bus.req_valid[ch] = 1'b0;
    endtask

    task automatic read_one(input int ch, input logic [AW-1:0] addr, input logic [TW-1:0] tag,
                            output logic [31:0] d, output logic [TW-1:0] t, output int lat);
        bit rdy;
        bit got;
        set_req(ch, 1'b0, addr, 4'h0, 32'h0, tag);
        for (int w = 0; w < 20 && !bus.req_ready[ch]; w++) step();
        rdy = bus.req_ready[ch];
        chk("rd_accept", 64'(rdy), 64'd1);
        step();
        bus.req_valid[ch] = 1'b0;
        got = 0;
        lat = 0;
        d   = '0;
        t   = '0;
        for (int w = 0; w < 20 && !got; w++) begin
            step();
            lat++;
            if (bus.rsp_valid[ch]) begin
                got = 1;
                d   = bus.rsp_data[ch*32 +: 32];
                t   = bus.rsp_tag[ch*TW +: TW];
            end
        end
        chk("rd_response_seen", 64'(got), 64'd1);
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin : p_stim
        logic [31:0]   d;
        logic [TW-1:0] t;
        int            lat;
        int            tg;
        bit            rd;
        logic [TW-1:0] seen [$];
        bit            got;

        reset_n       = 1'b0;
        clear_req();
        bus.rsp_ready = '1;
        repeat (3) step();
        reset_n = 1'b1;
        chk("ready_at_release", 64'(bus.req_ready), 64'h0);
        step();
        chk("ready_after_release", 64'(bus.req_ready), 64'hF);

        // Known contents for every word the bench touches.
        for (int a = 0; a < 128; a += NR) begin
            for (int ch = 0; ch < NR; ch++) set_req(ch, 1'b1, AW'(a + ch), 4'hF, 32'h0, '0);
            step();
        end
        clear_req();

        // Full write then read with latency measurement.
        write_one(0, 10'h012, 32'hDEADBEEF, 4'hF);
        read_one(0, 10'h012, 8'h5A, d, t, lat);
        chk("basic_latency", 64'(lat), 64'd2);
        chk("basic_data", 64'(d), 64'hDEADBEEF);
        chk("basic_tag",  64'(t), 64'h5A);

        // Partial write over zero.
        write_one(0, 10'h003, 32'h11223344, 4'b0101);
        read_one(0, 10'h003, 8'h33, d, t, lat);
        chk("partial_data", 64'(d), 64'h00220044);

        // Backpressure on channel 1.
        step();
        bus.rsp_ready[1] = 1'b0;
        tg = 1;
        for (int k = 0; k < 10; k++) begin
            if (tg <= 6) set_req(1, 1'b0, 10'h012, 4'h0, 32'h0, TW'(tg));
            else bus.req_valid[1] = 1'b0;
            rd = bus.req_ready[1];
            step();
            if (rd && tg <= 6) tg++;
        end
        chk("bp_accepts", 64'(tg - 1), 64'd4);
        bus.rsp_ready[1] = 1'b1;
        for (int k = 0; k < 40 && seen.size() < 6; k++) begin
            if (tg <= 6) set_req(1, 1'b0, 10'h012, 4'h0, 32'h0, TW'(tg));
            else bus.req_valid[1] = 1'b0;
            rd = bus.req_ready[1];
            if (bus.rsp_valid[1]) seen.push_back(bus.rsp_tag[1*TW +: TW]);
            step();
            if (rd && tg <= 6) tg++;
        end
        bus.req_valid[1] = 1'b0;
        chk("bp_rsp_count", 64'(seen.size()), 64'd6);
        for (int k = 0; k < 6 && k < seen.size(); k++) chk("bp_tag_order", 64'(seen[k]), 64'(k + 1));

        // Same-cycle write collision with a read.
        step();
        set_req(0, 1'b1, 10'h040, 4'b0011, 32'hAAAAAAAA, '0);
        set_req(2, 1'b1, 10'h040, 4'b1111, 32'hBBBBBBBB, '0);
        set_req(3, 1'b0, 10'h040, 4'h0,    32'h0,        8'h77);
        step();
        clear_req();
        got = 0;
        d   = '1;
        for (int w = 0; w < 10 && !got; w++) begin
            step();
            if (bus.rsp_valid[3]) begin
                got = 1;
                d   = bus.rsp_data[3*32 +: 32];
            end
        end
        chk("collide_rsp_seen", 64'(got), 64'd1);
        chk("collide_old_data", 64'(d), 64'h0);
        read_one(3, 10'h040, 8'h78, d, t, lat);
        chk("collide_merged", 64'(d), 64'hBBBBAAAA);

        // Reset with reads in flight.
        step();
        bus.rsp_ready[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_req(0, 1'b0, 10'h012, 4'h0, 32'h0, TW'(8'h10 + k));
            step();
        end
        clear_req();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        chk("rst_ready_low", 64'(bus.req_ready), 64'h0);
        chk("rst_no_rsp",    64'(bus.rsp_valid), 64'h0);
        step();
        chk("rst_ready_back", 64'(bus.req_ready), 64'hF);
        bus.rsp_ready[0] = 1'b1;
        repeat (4) step();
        chk("rst_still_no_rsp", 64'(bus.rsp_valid), 64'h0);
        read_one(0, 10'h012, 8'h21, d, t, lat);
        chk("rst_mem_kept", 64'(d), 64'hDEADBEEF);

        // Randomized traffic.
        for (int k = 0; k < 2000; k++) begin
            for (int ch = 0; ch < NR; ch++) begin
                if ($urandom_range(0, 2) != 0) begin
                    set_req(ch, ($urandom_range(0, 9) < 4),
                            AW'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 7)
                                                            : $urandom_range(0, 127)),
                            4'($urandom), $urandom, TW'($urandom));
                end else begin
                    bus.req_valid[ch] = 1'b0;
                end
                bus.rsp_ready[ch] = ($urandom_range(0, 3) != 0);
            end
            step();
        end
        clear_req();
        bus.rsp_ready = '1;
        repeat (20) step();
        chk("drain_idle", 64'(bus.rsp_valid), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : p_watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/tex_mem_responder.md
Name: tex_mem_responder

Overview:
- Memory-side responder for the texture unit's cache bus. It is the target end of the word-request interface that the texture memory requester drives.
- Accepts NUM_REQS independent word channels (read or byte-enabled write), serves them from a shared word-addressed SRAM model, and returns read data with the request tag after a fixed pipeline latency.
- Used as the texture cache stand-in for unit-level simulation and as a small on-chip texture store.

Parameters:
- NUM_REQS, 4, number of independent request/response channels
- ADDR_WIDTH, 10, word address width; memory depth 2^ADDR_WIDTH 32-bit words
- TAG_WIDTH, 8, per-channel request tag width, returned unmodified
- LATENCY, 2, read latency in cycles from request fire to rsp_valid; must be >= 1
- RSP_QUEUE_SIZE, 4, per-channel response queue depth; power of 2, >= 2

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- req_valid  in  NUM_REQS  per-channel request valid
- req_rw  in  NUM_REQS  1 = write, 0 = read
- req_addr  in  NUM_REQS*ADDR_WIDTH  word address
- req_byteen  in  NUM_REQS*4  write byte enables
- req_data  in  NUM_REQS*32  write data
- req_tag  in  NUM_REQS*TAG_WIDTH  request tag
- req_ready  out  NUM_REQS  per-channel request ready
- rsp_valid  out  NUM_REQS  read response valid
- rsp_data  out  NUM_REQS*32  read data
- rsp_tag  out  NUM_REQS*TAG_WIDTH  tag of the originating read
- rsp_ready  in  NUM_REQS  per-channel response ready
- perf_reads  out  32  total accepted reads
- perf_stalls  out  32  cycles in which any channel had req_valid=1 and req_ready=0

Behaviour:
- Interface: one clock (clk); reset_n is synchronous and active-low.
- Reset (reset_n=0 at a clk edge):
  - req_ready=0, rsp_valid=0, perf counters=0.
  - Credit counters, read pipelines and response queues are cleared.
  - Memory contents are not cleared.
  - Reads in flight when reset is asserted are dropped and produce no response.
  - req_ready rises to 1 in the first cycle after reset_n returns to 1.
- Handshake: a request fires when req_valid&req_ready; a response fires when rsp_valid&rsp_ready. Channels are fully independent.
- req_ready[i] = (credit[i] != RSP_QUEUE_SIZE). It is registered-state-derived only, with no combinational path from req_valid or rsp_ready.
- Credits: credit[i] counts reads in the pipeline plus in the queue.
  - +1 on read fire; -1 on response fire; unchanged if both occur in the same cycle.
  - The counter never exceeds RSP_QUEUE_SIZE.
- Writes:
  - Commit at the fire edge: each byte b of word addr is updated when byteen[b]=1.
  - Writes produce no response and consume no credit. They are still gated by req_ready.
- Reads:
  - The word is sampled at the fire edge and travels through a LATENCY-1 stage register pipeline with the tag.
  - It is written into the per-channel FIFO, so rsp_valid can assert exactly LATENCY cycles after the fire edge when the queue is empty and there is no backpressure.
  - Responses per channel are returned strictly in request order.
- Same-cycle collisions:
  - A read and a write to the same address in the same cycle: the read returns the old data.
  - Multiple writes to the same address in the same cycle: the lowest channel index wins per byte (byte-enable merged by priority).
- Queue:
  - rsp_valid is high whenever the FIFO is non-empty; rsp_data/rsp_tag hold stable while rsp_valid=1 and rsp_ready=0.
  - Credit gating guarantees the FIFO never overflows, so no stall-in-pipeline logic is needed.
  - On a full queue, the pointers wrap modulo RSP_QUEUE_SIZE.
- Addresses are used as-is; there is no out-of-range case (depth = 2^ADDR_WIDTH).

Optional Feature:
- Macro TEX_MEM_PERF_EN.
- Defined:
  - perf_reads increments by the number of read fires in each cycle (popcount across channels).
  - perf_stalls increments by 1 in any cycle where some channel has req_valid=1 and req_ready=0.
  - Both wrap at 2^32 and are cleared by reset.
- Undefined: both outputs are tied to 0 and no counter logic is instantiated.

Test Plan:
- Channel 0: write addr 0x012, data 0xDEADBEEF, byteen 4'b1111, then read 0x012 with tag 0x5A, rsp_ready=1. Expect rsp_valid exactly 2 cycles after the read fire, with data 0xDEADBEEF and tag 0x5A.
- Partial write: write 0x11223344 to addr 0x003 with byteen 4'b0101 over an initial 0x00000000, then read addr 0x003. Expect 0x00220044.
- Backpressure on channel 1 (rsp_ready=0): issue reads with tags 1..6. Expect:
  - req_ready drops after 4 accepts.
  - perf_stalls counts the stalled cycles (TEX_MEM_PERF_EN defined).
  - Raising rsp_ready returns tags 1,2,3,4 in order, then accepts 5 and 6.
- Same cycle, channels 0 and 2 both write addr 0x040: channel 0 writes 0xAAAAAAAA with byteen 4'b0011, channel 2 writes 0xBBBBBBBB with byteen 4'b1111, while channel 3 reads 0x040. Expect:
  - Channel 3 returns the old value.
  - A later read returns 0xBBBBAAAA.
- Reset mid-flight: issue 3 reads on channel 0, then assert reset_n=0 for 1 cycle. Expect:
  - No responses are produced.
  - Credit returns to 0 and req_ready=1 on the cycle after release.
  - Memory data written earlier is still readable.
- Build without TEX_MEM_PERF_EN: run the backpressure scenario. Expect perf_reads=perf_stalls=0 throughout.
